// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared UART definitions: character-width default, the transmit-arbiter
//   state encoding and a helper that sizes index fields.
//   No ports (package).
package uart_pkg;

    localparam int unsigned uart_data_bits_c = 8;

    typedef enum logic [1:0] {
        e_idle      = 2'd0,
        e_issue     = 2'd1,
        e_wait_done = 2'd2
    } uart_tx_arb_state_e;

    // Width of an index into n items; a single item still gets one bit.
    function automatic int unsigned uart_idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rr_arb.sv
// uart_rr_arb
//   Combinational round-robin pick: the first set request found searching
//   upward from rr_ptr_i, wrapping at num_req_p.
//   Ports:
//     req_i    [num_req_p-1:0]  request vector
//     rr_ptr_i [ptr_w-1:0]      index the search starts from
//     grant_o  [num_req_p-1:0]  one-hot winner, zero when no request
module uart_rr_arb
    import uart_pkg::*;
#(
    parameter  int num_req_p = 2,
    localparam int ptr_w     = uart_idx_width(num_req_p)
) (
    input  logic [num_req_p-1:0] req_i,
    input  logic [ptr_w-1:0]     rr_ptr_i,
    output logic [num_req_p-1:0] grant_o
);

    int               idx;
    logic [ptr_w-1:0] sel;
    logic             found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        sel     = '0;
        for (int k = 0; k < num_req_p; k++) begin
            idx = int'(rr_ptr_i) + k;
            if (idx >= num_req_p) begin
                idx = idx - num_req_p;
            end
            sel = ptr_w'(idx);
            if (!found && req_i[sel]) begin
                grant_o[sel] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb
//   Shares one UART transmitter between num_req_p requesters. A winner is
//   picked round-robin only when idle and keeps the transmitter until its
//   last character has completed, so packets never interleave.
//   Optional macro UART_TX_ARB_TIMEOUT_EN: a locked owner that leaves its
//   valid low for idle_timeout_p consecutive issue cycles loses the lock.
//   Ports:
//     clk_i, reset_i            clock, asynchronous active-high reset
//     req_v_i/req_data_i/req_last_i/req_ready_and_o  requester side
//     tx_v_o/tx_o/tx_ready_and_i/tx_done_i           transmitter side
//     grant_o                   one-hot current owner
//     busy_o                    high whenever not idle
//
//   state       | meaning
//   ------------+------------------------------------------------------
//   e_idle      | no owner; arbitrate among valid requesters
//   e_issue     | present owner's character until the transmitter takes it
//   e_wait_done | character accepted; wait for frame completion
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int num_req_p      = 2,
    parameter int data_bits_p    = uart_data_bits_c,
    parameter int idle_timeout_p = 1024
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [num_req_p-1:0]           req_v_i,
    input  logic [num_req_p*data_bits_p-1:0] req_data_i,
    input  logic [num_req_p-1:0]           req_last_i,
    output logic [num_req_p-1:0]           req_ready_and_o,
    output logic                           tx_v_o,
    output logic [data_bits_p-1:0]         tx_o,
    input  logic                           tx_ready_and_i,
    input  logic                           tx_done_i,
    output logic [num_req_p-1:0]           grant_o,
    output logic                           busy_o
);

    localparam int ptr_w = uart_idx_width(num_req_p);

    if (num_req_p < 2 || num_req_p > 8 || data_bits_p < 1 || idle_timeout_p < 1) begin : g_param_chk
        $error("uart_tx_arb: parameter out of range");
    end

    uart_tx_arb_state_e state_q, state_d;
    logic [num_req_p-1:0]   grant_q, grant_d;
    logic [ptr_w-1:0]       rr_ptr_q, rr_ptr_d;
    logic                   last_q, last_d;

    logic [num_req_p-1:0]   win_oh;
    logic [ptr_w-1:0]       grant_idx;
    logic [ptr_w-1:0]       nxt_ptr;
    logic                   v_sel;
    logic                   last_sel;
    logic [data_bits_p-1:0] data_sel;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int tmo_w = $clog2(idle_timeout_p + 1);
    localparam logic [tmo_w-1:0] tmo_load = tmo_w'(idle_timeout_p - 1);

    // sent_q: owner already has a character through, so the packet is locked.
    logic             sent_q, sent_d;
    logic [tmo_w-1:0] tmo_q, tmo_d;
`endif

    uart_rr_arb #(
        .num_req_p (num_req_p)
    ) u_rr_arb (
        .req_i    (req_v_i),
        .rr_ptr_i (rr_ptr_q),
        .grant_o  (win_oh)
    );

    // Owner's signals selected by the one-hot grant.
    always_comb begin
        v_sel     = |(req_v_i & grant_q);
        last_sel  = |(req_last_i & grant_q);
        data_sel  = '0;
        grant_idx = '0;
        for (int i = 0; i < num_req_p; i++) begin
            if (grant_q[i]) begin
                data_sel  = req_data_i[i*data_bits_p +: data_bits_p];
                grant_idx = ptr_w'(i);
            end
        end
        nxt_ptr = (grant_idx == ptr_w'(num_req_p - 1)) ? '0 : grant_idx + 1'b1;
    end

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        rr_ptr_d        = rr_ptr_q;
        last_d          = last_q;
        tx_v_o          = 1'b0;
        tx_o            = '0;
        req_ready_and_o = '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
        sent_d          = sent_q;
        tmo_d           = tmo_load;
`endif
        case (state_q)
            e_idle: begin
`ifdef UART_TX_ARB_TIMEOUT_EN
                sent_d = 1'b0;
`endif
                if (|req_v_i) begin
                    grant_d = win_oh;
                    state_d = e_issue;
                end
            end
            e_issue: begin
                tx_v_o          = v_sel;
                tx_o            = data_sel;
                req_ready_and_o = grant_q & {num_req_p{tx_ready_and_i}};
                if (v_sel && tx_ready_and_i) begin
                    last_d  = last_sel;
                    state_d = e_wait_done;
`ifdef UART_TX_ARB_TIMEOUT_EN
                    sent_d  = 1'b1;
                end else if (sent_q && !v_sel) begin
                    // tmo_q was loaded on the last non-counting cycle, so it
                    // hits zero on the idle_timeout_p-th consecutive idle cycle.
                    if (tmo_q == '0) begin
                        state_d  = e_idle;
                        grant_d  = '0;
                        rr_ptr_d = nxt_ptr;
                        sent_d   = 1'b0;
                    end else begin
                        tmo_d = tmo_q - 1'b1;
                    end
`endif
                end
            end
            e_wait_done: begin
                if (tx_done_i) begin
                    if (last_q) begin
                        state_d  = e_idle;
                        grant_d  = '0;
                        rr_ptr_d = nxt_ptr;
                    end else begin
                        state_d  = e_issue;
                    end
                end
            end
            default: begin
                state_d = e_idle;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= e_idle;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            last_q   <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            sent_q   <= 1'b0;
            tmo_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            last_q   <= last_d;
`ifdef UART_TX_ARB_TIMEOUT_EN
            sent_q   <= sent_d;
            tmo_q    <= tmo_d;
`endif
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = (state_q != e_idle);

endmodule
